nf_ahb_tmr: RTL and testbench

NF_AHB_TMR -- requirements
Module: nf_ahb_tmr

---
 rtl/nf_ahb_tmr.sv | 173 +++++++++++++++++
 tb/tb_nf_ahb_tmr.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_ahb_tmr.sv
// nf_ahb_tmr: zero-wait AHB-Lite timer slave with compare match and interrupt.
// Ports: hclk, hresetn; AHB slave haddr/hwdata/hrdata/hwrite/htrans/hsize/hburst/hresp/hready/hsel (_s); tmr_irq.
// Optional 8-bit prescaler when macro NF_TMR_PRESCALER_EN is defined.
module nf_ahb_tmr (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr_s,
  input  logic [31:0] hwdata_s,
  output logic [31:0] hrdata_s,
  input  logic        hwrite_s,
  input  logic [1:0]  htrans_s,
  input  logic [2:0]  hsize_s,
  input  logic [2:0]  hburst_s,
  output logic [1:0]  hresp_s,
  output logic        hready_s,
  input  logic        hsel_s,
  output logic        tmr_irq
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CNT  = 2'd1;
  localparam logic [1:0] A_CMP  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        unused_ok;
  assign unused_ok = ^{hsize_s, hburst_s, haddr_s[31:4], haddr_s[1:0]};

  assign hready_s = 1'b1;
  assign hresp_s  = 2'b00;

  // address-phase capture
  logic [1:0] addr_q;
  logic       wr_q;
  logic       vld_q;
  logic       accept;

  assign accept = hsel_s & htrans_s[1];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q <= 2'd0;
      wr_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        addr_q <= haddr_s[3:2];
        wr_q   <= hwrite_s;
      end
    end
  end

  logic bus_wr;
  logic bus_rd;
  logic wr_ctrl;
  logic wr_cnt;
  logic wr_cmp;
  logic wr_stat;

  assign bus_wr  = vld_q & wr_q;
  assign bus_rd  = vld_q & ~wr_q;
  assign wr_ctrl = bus_wr & (addr_q == A_CTRL);
  assign wr_cnt  = bus_wr & (addr_q == A_CNT);
  assign wr_cmp  = bus_wr & (addr_q == A_CMP);
  assign wr_stat = bus_wr & (addr_q == A_STAT);

  // timer state
  logic        en_q;
  logic        arl_q;
  logic        irqen_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] cmp_q;
  logic        match_q;
  logic        match_d;
  logic        tick;
  logic [7:0]  psc_rd;

`ifdef NF_TMR_PRESCALER_EN
  logic [7:0] psc_q;
  logic [7:0] pcnt_q;
  logic [7:0] pcnt_d;

  assign tick   = en_q & (pcnt_q == psc_q);
  assign psc_rd = psc_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (wr_ctrl) begin
      pcnt_d = 8'd0;
    end else if (en_q) begin
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      psc_q  <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
      if (wr_ctrl) begin
        psc_q <= hwdata_s[15:8];
      end
    end
  end
`else
  assign tick   = en_q;
  assign psc_rd = 8'd0;
`endif

  logic adv;
  logic hit;

  assign adv = en_q & tick;
  // compare always uses the pre-write count
  assign hit = (cnt_q == cmp_q);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt) begin
      cnt_d = hwdata_s;
    end else if (adv) begin
      cnt_d = (hit && arl_q) ? 32'd0 : cnt_q + 32'd1;
    end
  end

  // hardware set wins over a same-cycle software clear
  always_comb begin
    match_d = match_q & ~(wr_stat & hwdata_s[0]);
    if (adv && hit) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      en_q    <= 1'b0;
      arl_q   <= 1'b0;
      irqen_q <= 1'b0;
      cnt_q   <= 32'd0;
      cmp_q   <= 32'd0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      match_q <= match_d;
      if (wr_ctrl) begin
        en_q    <= hwdata_s[0];
        arl_q   <= hwdata_s[1];
        irqen_q <= hwdata_s[2];
      end
      if (wr_cmp) begin
        cmp_q <= hwdata_s;
      end
    end
  end

  assign tmr_irq = match_q & irqen_q;

  always_comb begin
    hrdata_s = 32'd0;
    if (bus_rd) begin
      case (addr_q)
        A_CTRL:  hrdata_s = {16'd0, psc_rd, 5'd0, irqen_q, arl_q, en_q};
        A_CNT:   hrdata_s = cnt_q;
        A_CMP:   hrdata_s = cmp_q;
        A_STAT:  hrdata_s = {31'd0, match_q};
        default: hrdata_s = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_ahb_tmr.sv
// tb_nf_ahb_tmr: directed self-checking bench for nf_ahb_tmr.
// Bus transfers driven on the falling edge; outputs sampled on the falling edge.
module tb_nf_ahb_tmr;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr_s;
  logic [31:0] hwdata_s;
  logic [31:0] hrdata_s;
  logic        hwrite_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s;
  logic [2:0]  hburst_s;
  logic [1:0]  hresp_s;
  logic        hready_s;
  logic        hsel_s;
  logic        tmr_irq;

  nf_ahb_tmr dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .haddr_s  (haddr_s),
    .hwdata_s (hwdata_s),
    .hrdata_s (hrdata_s),
    .hwrite_s (hwrite_s),
    .htrans_s (htrans_s),
    .hsize_s  (hsize_s),
    .hburst_s (hburst_s),
    .hresp_s  (hresp_s),
    .hready_s (hready_s),
    .hsel_s   (hsel_s),
    .tmr_irq  (tmr_irq)
  );

  always #5 hclk = ~hclk;

  localparam logic [31:0] R_CTRL = 32'h0;
  localparam logic [31:0] R_CNT  = 32'h4;
  localparam logic [31:0] R_CMP  = 32'h8;
  localparam logic [31:0] R_STAT = 32'hC;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_d[$];
  logic [31:0] q_irq[$];
  logic [31:0] rv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    hsel_s   = 1'b0;
    htrans_s = 2'b00;
    hwrite_s = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge hclk);
    haddr_s  = a;
    hwrite_s = 1'b1;
    htrans_s = 2'b10;
    hsel_s   = 1'b1;
    @(negedge hclk);
    hwdata_s = d;
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge hclk);
    haddr_s  = a;
    hwrite_s = 1'b0;
    htrans_s = 2'b10;
    hsel_s   = 1'b1;
    @(negedge hclk);
    bus_idle();
    d = hrdata_s;
  endtask

  // back-to-back reads of one register, one sample per cycle
  task automatic rd_stream(input logic [31:0] a, input int n);
    q_d.delete();
    q_irq.delete();
    for (int i = 0; i <= n; i++) begin
      @(negedge hclk);
      if (i > 0) begin
        q_d.push_back(hrdata_s);
        q_irq.push_back({31'd0, tmr_irq});
      end
      if (i < n) begin
        haddr_s  = a;
        hwrite_s = 1'b0;
        htrans_s = 2'b10;
        hsel_s   = 1'b1;
      end else begin
        bus_idle();
      end
    end
  endtask

  logic [31:0] exp_cnt[7];
  logic [31:0] exp_irq[7];

  initial begin
    hresetn  = 1'b0;
    haddr_s  = '0;
    hwdata_s = '0;
    hsize_s  = 3'b010;
    hburst_s = 3'b000;
    bus_idle();
    exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
    exp_irq = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};

    repeat (2) @(negedge hclk);
    chk("rst_hrdata", hrdata_s, 32'd0);
    chk("rst_irq", {31'd0, tmr_irq}, 32'd0);
    chk("rst_hready", {31'd0, hready_s}, 32'd1);
    chk("rst_hresp", {30'd0, hresp_s}, 32'd0);
    hresetn = 1'b1;

    // back-to-back write CMP then read CMP
    @(negedge hclk);
    haddr_s  = R_CMP;
    hwrite_s = 1'b1;
    htrans_s = 2'b10;
    hsel_s   = 1'b1;
    @(negedge hclk);
    hwdata_s = 32'hA;
    hwrite_s = 1'b0;
    chk("wdata_phase_hrdata", hrdata_s, 32'd0);
    chk("b2b_hready0", {31'd0, hready_s}, 32'd1);
    @(negedge hclk);
    bus_idle();
    chk("b2b_read_cmp", hrdata_s, 32'hA);
    chk("b2b_hready1", {31'd0, hready_s}, 32'd1);

    // IDLE and BUSY with hsel high must not write
    @(negedge hclk);
    haddr_s  = R_CMP;
    hwrite_s = 1'b1;
    htrans_s = 2'b00;
    hsel_s   = 1'b1;
    @(negedge hclk);
    hwdata_s = 32'hBAD;
    htrans_s = 2'b01;
    @(negedge hclk);
    hwdata_s = 32'hBEEF;
    bus_idle();
    rd(R_CMP, rv);
    chk("idle_no_write", rv, 32'hA);

    // basic count with autoreload and irq
    wr(R_CMP, 32'd5);
    wr(R_CTRL, 32'h7);
    rd_stream(R_CNT, 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("cnt_seq%0d", i), q_d[i], exp_cnt[i]);
      chk($sformatf("irq_seq%0d", i), q_irq[i], exp_irq[i]);
    end

    // reset in the data phase of a CMP write
    @(negedge hclk);
    haddr_s  = R_CMP;
    hwrite_s = 1'b1;
    htrans_s = 2'b10;
    hsel_s   = 1'b1;
    @(negedge hclk);
    hwdata_s = 32'h1234;
    bus_idle();
    hresetn = 1'b0;
    #1;
    chk("midrst_hrdata", hrdata_s, 32'd0);
    chk("midrst_irq", {31'd0, tmr_irq}, 32'd0);
    chk("midrst_hready", {31'd0, hready_s}, 32'd1);
    chk("midrst_hresp", {30'd0, hresp_s}, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    rd(R_CTRL, rv);
    chk("post_rst_ctrl", rv, 32'd0);
    rd(R_CNT, rv);
    chk("post_rst_cnt", rv, 32'd0);
    rd(R_CMP, rv);
    chk("post_rst_cmp", rv, 32'd0);
    rd(R_STAT, rv);
    chk("post_rst_stat", rv, 32'd0);
    wr(R_CMP, 32'h77);
    rd(R_CMP, rv);
    chk("post_rst_first_xfer", rv, 32'h77);

    // STAT clear in the same cycle MATCH is set
    wr(R_CMP, 32'd3);
    wr(R_CTRL, 32'h5);
    repeat (2) @(negedge hclk);
    wr(R_STAT, 32'd1);
    rd(R_STAT, rv);
    chk("race_stat", rv, 32'd1);
    chk("race_irq", {31'd0, tmr_irq}, 32'd1);
    wr(R_STAT, 32'd1);
    rd(R_STAT, rv);
    chk("clear_stat", rv, 32'd0);
    chk("clear_irq", {31'd0, tmr_irq}, 32'd0);

    // free-running wrap
    wr(R_CTRL, 32'h0);
    wr(R_CNT, 32'hFFFF_FFFE);
    wr(R_CMP, 32'h10);
    wr(R_STAT, 32'd1);
    wr(R_CTRL, 32'h1);
    rd_stream(R_CNT, 2);
    chk("wrap_ff", q_d[0], 32'hFFFF_FFFF);
    chk("wrap_00", q_d[1], 32'h0);
    rd(R_STAT, rv);
    chk("wrap_nomatch", rv, 32'd0);

    // CNT write beats advance; compare sees pre-write CNT
    wr(R_CTRL, 32'h0);
    wr(R_CNT, 32'd0);
    wr(R_CMP, 32'd2);
    wr(R_STAT, 32'd1);
    wr(R_CTRL, 32'h1);
    @(negedge hclk);
    wr(R_CNT, 32'h100);
    rd_stream(R_CNT, 2);
    chk("prio_cnt0", q_d[0], 32'h101);
    chk("prio_cnt1", q_d[1], 32'h102);
    rd(R_STAT, rv);
    chk("prio_match", rv, 32'd1);
    chk("prio_irq_off", {31'd0, tmr_irq}, 32'd0);

    // prescaler
    wr(R_CTRL, 32'h0);
    wr(R_CNT, 32'd0);
    wr(R_STAT, 32'd1);
    wr(R_CMP, 32'd2);
    wr(R_CTRL, 32'h0301);
    wr(R_CMP, 32'd2);
    rd_stream(R_CNT, 10);
    for (int k = 0; k < 10; k++) begin
`ifdef NF_TMR_PRESCALER_EN
      chk($sformatf("psc_cnt%0d", k), q_d[k], 32'((k + 3) / 4));
`else
      chk($sformatf("psc_cnt%0d", k), q_d[k], 32'(k + 3));
`endif
    end
    rd(R_STAT, rv);
    chk("psc_match", rv, 32'd1);
    rd(R_CTRL, rv);
`ifdef NF_TMR_PRESCALER_EN
    chk("psc_ctrl", rv, 32'h0301);
`else
    chk("psc_ctrl", rv, 32'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
